// File: rtl/uart_axi4_pkg.sv
// Shared definitions for the UART AXI4 controller.
// Contents: register offsets, AXI response codes, transmitter state type
// and STATUS register bit positions.
package uart_axi4_pkg;

  localparam logic [31:0] UART_TXDATA_OFS = 32'h0;
  localparam logic [31:0] UART_STATUS_OFS = 32'h4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_CNT_LSB   = 8;
  localparam int STAT_CNT_MSB   = 11;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the AXI write path and the serial transmitter.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   push, push_data     : write request and data (ignored when full)
//   pop, pop_data       : read request (ignored when empty), head entry
//   full, empty, count  : occupancy flags and entry count
module uart_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_axi4_ctrl.sv
// AXI4 slave exposing a UART transmitter: TXDATA (BASE+0, write-only) and
// STATUS (BASE+4, read-only), a byte FIFO and an 8N1 serial sequencer
// paced by a baud counter on the core clock.
// Ports:
//   CLK, RST_N          : core clock, synchronous active-low reset
//   slave_AW*/W*/B*     : AXI4 write address, data and response channels
//   slave_AR*/R*        : AXI4 read address and data channels
//   uart_tx             : registered serial output, idle high
//   tx_busy             : FIFO non-empty or frame in progress
module uart_axi4_ctrl
  import uart_axi4_pkg::*;
#(
  parameter logic [31:0] UART_BASE  = 32'h9000_0000,
  parameter int          BAUD_DIV   = 1250,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        slave_AWVALID,
  output logic        slave_AWREADY,
  input  logic [31:0] slave_AWADDR,
  input  logic [3:0]  slave_AWID,
  input  logic [7:0]  slave_AWLEN,
  input  logic        slave_WVALID,
  output logic        slave_WREADY,
  input  logic [31:0] slave_WDATA,
  input  logic [3:0]  slave_WSTRB,
  input  logic        slave_WLAST,
  output logic        slave_BVALID,
  input  logic        slave_BREADY,
  output logic [1:0]  slave_BRESP,
  output logic [3:0]  slave_BID,
  input  logic        slave_ARVALID,
  output logic        slave_ARREADY,
  input  logic [31:0] slave_ARADDR,
  input  logic [3:0]  slave_ARID,
  input  logic [7:0]  slave_ARLEN,
  output logic        slave_RVALID,
  input  logic        slave_RREADY,
  output logic [31:0] slave_RDATA,
  output logic [1:0]  slave_RRESP,
  output logic [3:0]  slave_RID,
  output logic        slave_RLAST,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BD_W  = $clog2(BAUD_DIV + 1);

  // Keeps READY low in the first cycle after reset.
  logic              up;
  logic              aw_held, w_held;
  logic [31:0]       aw_addr_q;
  logic [3:0]        aw_id_q;
  logic [7:0]        aw_len_q;
  logic [7:0]        w_data_q;
  logic              w_strb0_q;
  logic [31:0]       aw_ofs, ar_ofs;
  logic              wr_ok, wr_is_tx, wr_exec, rd_ok, rd_is_status;
  logic [31:0]       status_word;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  tx_state_t         state, state_n;
  logic [BD_W-1:0]   baud, baud_n;
  logic [2:0]        idx, idx_n;
  logic [7:0]        shift, shift_n;
  logic              tx_n, baud_wrap;
  logic              unused_inputs;

  assign unused_inputs = ^{slave_WDATA[31:8], slave_WSTRB[3:1], slave_WLAST};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8), .CNT_W(CNT_W)) u_fifo (
    .clk(CLK), .rst_n(RST_N), .push(fifo_push), .push_data(w_data_q),
    .pop(fifo_pop), .pop_data(fifo_rdata), .full(fifo_full),
    .empty(fifo_empty), .count(fifo_count)
  );

  assign slave_AWREADY = up & ~aw_held & ~slave_BVALID;
  assign slave_WREADY  = up & ~w_held & ~slave_BVALID;
  assign slave_ARREADY = up & ~slave_RVALID;
  assign slave_RLAST   = slave_RVALID;
  assign tx_busy       = (state != IDLE) | ~fifo_empty;

  // Window check is an unsigned offset compare, so addresses below BASE fail too.
  assign aw_ofs   = aw_addr_q - UART_BASE;
  assign wr_ok    = (aw_ofs[31:3] == '0) && (aw_len_q == '0);
  assign wr_is_tx = wr_ok && (aw_ofs[2:0] < UART_STATUS_OFS[2:0]) && w_strb0_q;
  // A push into a full FIFO stalls the whole write until a slot frees.
  assign wr_exec   = aw_held && w_held && !slave_BVALID && !(wr_is_tx && fifo_full);
  assign fifo_push = wr_exec && wr_is_tx;

  assign ar_ofs       = slave_ARADDR - UART_BASE;
  assign rd_ok        = (ar_ofs[31:3] == '0) && (slave_ARLEN == '0);
  assign rd_is_status = rd_ok && (ar_ofs[2:0] >= UART_STATUS_OFS[2:0]);

  always_comb begin
    status_word = '0;
    status_word[STAT_FULL_BIT]  = fifo_full;
    status_word[STAT_EMPTY_BIT] = fifo_empty;
    status_word[STAT_BUSY_BIT]  = tx_busy;
    status_word[STAT_CNT_MSB:STAT_CNT_LSB] = 4'(fifo_count);
  end

  // AXI control and response registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      up           <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      slave_BVALID <= 1'b0;
      slave_BRESP  <= RESP_OKAY;
      slave_BID    <= '0;
      slave_RVALID <= 1'b0;
      slave_RDATA  <= '0;
      slave_RRESP  <= RESP_OKAY;
      slave_RID    <= '0;
    end else begin
      up <= 1'b1;
      if (slave_AWVALID && slave_AWREADY) aw_held <= 1'b1;
      if (slave_WVALID && slave_WREADY)   w_held  <= 1'b1;
      if (wr_exec) begin
        slave_BVALID <= 1'b1;
        slave_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        slave_BID    <= aw_id_q;
      end else if (slave_BVALID && slave_BREADY) begin
        slave_BVALID <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
      if (slave_ARVALID && slave_ARREADY) begin
        slave_RVALID <= 1'b1;
        slave_RDATA  <= rd_is_status ? status_word : '0;
        slave_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        slave_RID    <= slave_ARID;
      end else if (slave_RVALID && slave_RREADY) begin
        slave_RVALID <= 1'b0;
      end
    end
  end

  // Write holding data
  always_ff @(posedge CLK) begin
    if (slave_AWVALID && slave_AWREADY) begin
      aw_addr_q <= slave_AWADDR;
      aw_id_q   <= slave_AWID;
      aw_len_q  <= slave_AWLEN;
    end
    if (slave_WVALID && slave_WREADY) begin
      w_data_q  <= slave_WDATA[7:0];
      w_strb0_q <= slave_WSTRB[0];
    end
  end

  // uart_tx is registered, so tx_n carries the line level of the next state.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    idx_n     = idx;
    shift_n   = shift;
    tx_n      = uart_tx;
    fifo_pop  = 1'b0;
    baud_wrap = (baud == BD_W'(BAUD_DIV - 1));
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_rdata;
          baud_n   = '0;
          state_n  = START;
          tx_n     = 1'b0;
        end
      end
      START: begin
        baud_n = baud_wrap ? '0 : baud + BD_W'(1);
        if (baud_wrap) begin
          state_n = DATA;
          idx_n   = 3'd0;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        baud_n = baud_wrap ? '0 : baud + BD_W'(1);
        if (baud_wrap) begin
          if (idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shift[idx + 3'd1];
          end
        end
      end
      STOP: begin
        baud_n = baud_wrap ? '0 : baud + BD_W'(1);
        tx_n   = 1'b1;
        if (baud_wrap) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Transmitter state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      baud    <= '0;
      idx     <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      idx     <= idx_n;
      uart_tx <= tx_n;
    end
  end

  always_ff @(posedge CLK) begin
    shift <= shift_n;
  end

endmodule

// File: tb/tb_uart_axi4_ctrl.sv
module tb_uart_axi4_ctrl;

  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int BD = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        slave_AWVALID, slave_AWREADY;
  logic [31:0] slave_AWADDR;
  logic [3:0]  slave_AWID;
  logic [7:0]  slave_AWLEN;
  logic        slave_WVALID, slave_WREADY;
  logic [31:0] slave_WDATA;
  logic [3:0]  slave_WSTRB;
  logic        slave_WLAST;
  logic        slave_BVALID, slave_BREADY;
  logic [1:0]  slave_BRESP;
  logic [3:0]  slave_BID;
  logic        slave_ARVALID, slave_ARREADY;
  logic [31:0] slave_ARADDR;
  logic [3:0]  slave_ARID;
  logic [7:0]  slave_ARLEN;
  logic        slave_RVALID, slave_RREADY;
  logic [31:0] slave_RDATA;
  logic [1:0]  slave_RRESP;
  logic [3:0]  slave_RID;
  logic        slave_RLAST;
  logic        uart_tx, tx_busy;

  int checks = 0;
  int failures = 0;
  int rx_done = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  uart_axi4_ctrl #(.UART_BASE(BASE), .BAUD_DIV(BD), .FIFO_DEPTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .slave_AWVALID(slave_AWVALID), .slave_AWREADY(slave_AWREADY),
    .slave_AWADDR(slave_AWADDR), .slave_AWID(slave_AWID), .slave_AWLEN(slave_AWLEN),
    .slave_WVALID(slave_WVALID), .slave_WREADY(slave_WREADY),
    .slave_WDATA(slave_WDATA), .slave_WSTRB(slave_WSTRB), .slave_WLAST(slave_WLAST),
    .slave_BVALID(slave_BVALID), .slave_BREADY(slave_BREADY),
    .slave_BRESP(slave_BRESP), .slave_BID(slave_BID),
    .slave_ARVALID(slave_ARVALID), .slave_ARREADY(slave_ARREADY),
    .slave_ARADDR(slave_ARADDR), .slave_ARID(slave_ARID), .slave_ARLEN(slave_ARLEN),
    .slave_RVALID(slave_RVALID), .slave_RREADY(slave_RREADY),
    .slave_RDATA(slave_RDATA), .slave_RRESP(slave_RRESP), .slave_RID(slave_RID),
    .slave_RLAST(slave_RLAST), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level c cycles into a frame: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int c);
    int k;
    k = c / BD;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] id,
                           input logic [7:0] len, output logic [1:0] resp,
                           output logic [3:0] bid_o, output int lat);
    int n;
    logic aw_go, w_go;
    n = 0;
    slave_AWADDR = addr; slave_AWID = id; slave_AWLEN = len;
    slave_WDATA = data; slave_WSTRB = strb; slave_WLAST = 1'b1;
    slave_AWVALID = 1'b1; slave_WVALID = 1'b1;
    while ((slave_AWVALID || slave_WVALID) && n < 500) begin
      aw_go = slave_AWREADY; w_go = slave_WREADY;
      @(negedge CLK); n++;
      if (aw_go) slave_AWVALID = 1'b0;
      if (w_go)  slave_WVALID = 1'b0;
    end
    while (!slave_BVALID && n < 500) begin @(negedge CLK); n++; end
    chk("wr_complete", n < 500, 1);
    slave_AWVALID = 1'b0; slave_WVALID = 1'b0;
    lat = n; resp = slave_BRESP; bid_o = slave_BID;
    @(negedge CLK);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, output logic [31:0] data,
                          output logic [1:0] resp, output logic [3:0] rid_o,
                          output logic last, output int lat);
    int n;
    logic go;
    n = 0; lat = 0;
    slave_ARADDR = addr; slave_ARLEN = len; slave_ARID = id; slave_ARVALID = 1'b1;
    while (slave_ARVALID && n < 500) begin
      go = slave_ARREADY;
      @(negedge CLK); n++;
      if (go) slave_ARVALID = 1'b0;
    end
    slave_ARVALID = 1'b0;
    while (!slave_RVALID && n < 500) begin @(negedge CLK); n++; lat++; end
    chk("rd_complete", n < 500, 1);
    data = slave_RDATA; resp = slave_RRESP; rid_o = slave_RID; last = slave_RLAST;
    @(negedge CLK);
  endtask

  // Behavioural 8N1 receiver sampling mid-bit.
  task automatic rx_frame(output logic [7:0] b);
    int n;
    n = 0; b = '0;
    while (uart_tx !== 1'b0 && n < 3000) begin @(negedge CLK); n++; end
    chk("rx_start_seen", n < 3000, 1);
    if (n < 3000) begin
      repeat (2) @(negedge CLK);
      chk("rx_start_mid", uart_tx, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge CLK);
        b[i] = uart_tx;
      end
      repeat (BD) @(negedge CLK);
      chk("rx_stop_mid", uart_tx, 1);
    end
    rx_done++;
  endtask

  task automatic rx_expect(input int nframes);
    logic [7:0] rb;
    logic [31:0] ev;
    for (int k = 0; k < nframes; k++) begin
      rx_frame(rb);
      ev = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD;
      chk("rx_byte", {24'h0, rb}, ev);
    end
  endtask

  initial begin
    logic [1:0]  resp;
    logic [3:0]  id, rid;
    logic [31:0] rdata;
    logic        last;
    int          lat, t0;
    logic [7:0]  b;

    RST_N = 1'b0;
    slave_AWVALID = 0; slave_AWADDR = 0; slave_AWID = 0; slave_AWLEN = 0;
    slave_WVALID = 0; slave_WDATA = 0; slave_WSTRB = 0; slave_WLAST = 0;
    slave_BREADY = 1; slave_ARVALID = 0; slave_ARADDR = 0; slave_ARID = 0;
    slave_ARLEN = 0; slave_RREADY = 1;
    repeat (3) @(negedge CLK);
    chk("rst_awready", slave_AWREADY, 0);
    chk("rst_wready", slave_WREADY, 0);
    chk("rst_arready", slave_ARREADY, 0);
    chk("rst_bvalid", slave_BVALID, 0);
    chk("rst_rvalid", slave_RVALID, 0);
    chk("rst_resp_ids", {slave_BRESP, slave_RRESP, slave_BID, slave_RID}, 0);
    chk("rst_rdata", slave_RDATA, 0);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tx_busy", tx_busy, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Single write of 0x41, AW and W together, exact frame waveform
    id = 4'($urandom);
    chk("t1_awready", slave_AWREADY, 1);
    chk("t1_wready", slave_WREADY, 1);
    slave_AWADDR = BASE; slave_AWID = id; slave_AWLEN = 0;
    slave_WDATA = 32'h41; slave_WSTRB = 4'hF; slave_WLAST = 1;
    slave_AWVALID = 1; slave_WVALID = 1;
    @(negedge CLK);
    slave_AWVALID = 0; slave_WVALID = 0;
    chk("t1_bvalid_early", slave_BVALID, 0);
    chk("t1_awready_held", slave_AWREADY, 0);
    @(negedge CLK);
    chk("t1_bvalid", slave_BVALID, 1);
    chk("t1_bresp", slave_BRESP, 2'b00);
    chk("t1_bid", slave_BID, id);
    @(negedge CLK);
    chk("t1_bvalid_drop", slave_BVALID, 0);
    for (int c = 0; c <= 10 * BD; c++) begin
      chk($sformatf("t1_line_c%0d", c), uart_tx, frame_bit(8'h41, c));
      @(negedge CLK);
    end
    chk("t1_idle_busy", tx_busy, 0);

    // W three cycles ahead of AW
    b = 8'($urandom);
    chk("t2_wready", slave_WREADY, 1);
    slave_WDATA = {24'h0, b}; slave_WSTRB = 4'h1; slave_WVALID = 1;
    @(negedge CLK);
    slave_WVALID = 0;
    repeat (3) begin
      chk("t2_no_b", slave_BVALID, 0);
      chk("t2_wready_held", slave_WREADY, 0);
      chk("t2_awready", slave_AWREADY, 1);
      @(negedge CLK);
    end
    id = 4'($urandom);
    slave_AWADDR = BASE; slave_AWID = id; slave_AWLEN = 0; slave_AWVALID = 1;
    @(negedge CLK);
    slave_AWVALID = 0;
    lat = 0;
    while (!slave_BVALID && lat < 100) begin @(negedge CLK); lat++; end
    chk("t2_bvalid", slave_BVALID, 1);
    chk("t2_bid", slave_BID, id);
    @(negedge CLK);
    exp_q.push_back(b);
    rx_expect(1);
    repeat (20) @(negedge CLK);
    chk("t2_single_byte_busy", tx_busy, 0);
    chk("t2_line_idle", uart_tx, 1);

    // Ten back-to-back writes against an 8-deep FIFO
    rx_done = 0;
    fork
      begin : writer3
        logic [7:0] wb;
        logic [1:0] wr;
        logic [3:0] wid, wbid;
        int wl;
        for (int k = 0; k < 10; k++) begin
          wb = 8'($urandom); wid = 4'($urandom);
          exp_q.push_back(wb);
          axi_write(BASE, {24'($urandom), wb}, 4'hF, wid, 8'd0, wr, wbid, wl);
          chk("t3_bresp", wr, 2'b00);
          chk("t3_bid", wbid, wid);
          if (k < 9) chk("t3_fast_write", wl <= 3, 1);
          else begin
            chk("t3_stalled_write", wl > 4, 1);
            chk("t3_after_first_frame", rx_done >= 1, 1);
          end
        end
      end
      begin : reader3
        rx_expect(10);
      end
    join

    // STATUS mid-frame with three bytes queued
    fork
      begin : writer4
        logic [1:0] wr;
        logic [3:0] wbid;
        int wl;
        for (int k = 0; k < 4; k++) begin
          b = 8'($urandom);
          exp_q.push_back(b);
          axi_write(BASE + 32'h1 * 0, {24'h0, b}, 4'h1, 4'(k), 8'd0, wr, wbid, wl);
        end
        id = 4'($urandom);
        axi_read(BASE + 32'h4, 8'd0, id, rdata, resp, rid, last, lat);
        chk("t4_status", rdata, (32'd3 << 8) | (32'd1 << 2));
        chk("t4_rresp", resp, 2'b00);
        chk("t4_rlast", last, 1);
        chk("t4_rid", rid, id);
        chk("t4_r_latency", lat, 0);
      end
      begin : reader4
        rx_expect(4);
      end
    join
    repeat (5) @(negedge CLK);

    // Error responses and ignored writes, FIFO untouched
    id = 4'($urandom);
    axi_write(BASE + 32'h10, 32'h55, 4'hF, id, 8'd0, resp, rid, lat);
    chk("t5_oow_bresp", resp, 2'b10);
    chk("t5_oow_bid", rid, id);
    axi_write(BASE, 32'h66, 4'hF, 4'h3, 8'd1, resp, rid, lat);
    chk("t5_len_bresp", resp, 2'b10);
    axi_write(BASE, 32'h77, 4'hE, 4'h4, 8'd0, resp, rid, lat);
    chk("t5_nostrb_bresp", resp, 2'b00);
    axi_write(BASE + 32'h4, 32'h88, 4'hF, 4'h5, 8'd0, resp, rid, lat);
    chk("t5_status_wr_bresp", resp, 2'b00);
    id = 4'($urandom);
    axi_read(BASE + 32'h4, 8'd3, id, rdata, resp, rid, last, lat);
    chk("t5_arlen_rdata", rdata, 0);
    chk("t5_arlen_rresp", resp, 2'b10);
    chk("t5_arlen_rlast", last, 1);
    chk("t5_arlen_rid", rid, id);
    axi_read(BASE, 8'd0, 4'h2, rdata, resp, rid, last, lat);
    chk("t5_txdata_rdata", rdata, 0);
    chk("t5_txdata_rresp", resp, 2'b00);
    axi_read(BASE - 32'h4, 8'd0, 4'h1, rdata, resp, rid, last, lat);
    chk("t5_below_rresp", resp, 2'b10);
    axi_read(BASE + 32'h4, 8'd0, 4'h6, rdata, resp, rid, last, lat);
    chk("t5_status_unchanged", rdata, 32'h2);
    chk("t5_no_busy", tx_busy, 0);
    chk("t5_line_idle", uart_tx, 1);

    // Reset during data bit 3 with a second byte still queued
    b = 8'($urandom) & 8'hF7;
    axi_write(BASE, {24'h0, b}, 4'h1, 4'h7, 8'd0, resp, rid, lat);
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 100) begin @(negedge CLK); lat++; end
    t0 = cyc;
    axi_write(BASE, 32'hA5, 4'h1, 4'h8, 8'd0, resp, rid, lat);
    lat = 0;
    while (cyc < t0 + 4 * BD + 1 && lat < 100) begin @(negedge CLK); lat++; end
    chk("t6_bit3_low", uart_tx, 0);
    chk("t6_busy_before", tx_busy, 1);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("t6_rst_line", uart_tx, 1);
    chk("t6_rst_busy", tx_busy, 0);
    chk("t6_rst_awready", slave_AWREADY, 0);
    RST_N = 1'b1;
    axi_read(BASE + 32'h4, 8'd0, 4'h9, rdata, resp, rid, last, lat);
    chk("t6_status", rdata, 32'h2);
    repeat (60) @(negedge CLK);
    chk("t6_no_frame_busy", tx_busy, 0);
    chk("t6_no_frame_line", uart_tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
